// File: rtl/pc_sequencer.sv
// Fetch-head program counter with redirect, stall, pc-relative jump and a circular return-address stack.
// Optional feature macro: PC_MISALIGN_TRAP_EN (misaligned non-sequential targets go to TRAP_VECTOR).
module pc_sequencer #(
    parameter int unsigned         XLEN         = 32,
    parameter logic [XLEN-1:0]     RESET_VECTOR = '0,
    parameter int unsigned         STEP         = 4,
    parameter int unsigned         RAS_DEPTH    = 4,
    parameter logic [XLEN-1:0]     TRAP_VECTOR  = XLEN'('h100)
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             stall,
    input  logic                             redirect,
    input  logic [XLEN-1:0]                  redirect_target,
    input  logic                             jump,
    input  logic [XLEN-1:0]                  jump_offset,
    input  logic                             call,
    input  logic                             ret,
    output logic [XLEN-1:0]                  instruction_addr,
    output logic [$clog2(RAS_DEPTH+1)-1:0]   ras_count,
    output logic                             ras_miss,
    output logic                             misaligned
);

    localparam int unsigned CW = $clog2(RAS_DEPTH + 1);
    localparam int unsigned PW = $clog2(RAS_DEPTH);

    logic [XLEN-1:0] pc_q, pc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]   top_q, top_d;
    logic            miss_q, miss_d;
    logic            mis_q, mis_d;
    logic [XLEN-1:0] ras_q [RAS_DEPTH];

    logic [XLEN-1:0] seq_pc, tgt;
    logic            take_tgt, op_push, op_pop, op_repl;
    logic            wr_en;
    logic [PW-1:0]   wr_idx, top_inc, top_dec;

    // Circular pointer arithmetic; depth need not be a power of two.
    assign top_inc = (top_q == PW'(RAS_DEPTH - 1)) ? '0 : top_q + PW'(1);
    assign top_dec = (top_q == '0) ? PW'(RAS_DEPTH - 1) : top_q - PW'(1);

    always_comb begin
        seq_pc   = pc_q + XLEN'(STEP);
        pc_d     = seq_pc;
        cnt_d    = cnt_q;
        top_d    = top_q;
        miss_d   = 1'b0;
        mis_d    = 1'b0;
        tgt      = '0;
        take_tgt = 1'b0;
        op_push  = 1'b0;
        op_pop   = 1'b0;
        op_repl  = 1'b0;
        wr_en    = 1'b0;
        wr_idx   = top_q;

        if (redirect) begin
            tgt      = redirect_target;
            take_tgt = 1'b1;
        end else if (stall) begin
            pc_d = pc_q;
        end else if (ret) begin
            if (cnt_q == '0) begin
                miss_d  = 1'b1;
                op_push = call;
            end else begin
                tgt      = ras_q[top_q];
                take_tgt = 1'b1;
                op_repl  = call;
                op_pop   = !call;
            end
        end else if (jump) begin
            tgt      = pc_q + jump_offset;
            take_tgt = 1'b1;
            op_push  = call;
        end

        if (take_tgt) begin
`ifdef PC_MISALIGN_TRAP_EN
            // Trapped cycles leave the stack untouched.
            if ((tgt & XLEN'(STEP - 1)) != '0) begin
                pc_d    = TRAP_VECTOR;
                mis_d   = 1'b1;
                op_push = 1'b0;
                op_pop  = 1'b0;
                op_repl = 1'b0;
            end else begin
                pc_d = tgt;
            end
`else
            pc_d = tgt;
`endif
        end

        if (op_push) begin
            top_d  = top_inc;
            wr_en  = 1'b1;
            wr_idx = top_inc;
            cnt_d  = (cnt_q == CW'(RAS_DEPTH)) ? cnt_q : cnt_q + CW'(1);
        end
        if (op_pop) begin
            top_d = top_dec;
            cnt_d = cnt_q - CW'(1);
        end
        if (op_repl) begin
            wr_en = 1'b1;
        end
    end

`ifndef PC_MISALIGN_TRAP_EN
    logic unused_trap;
    assign unused_trap = ^TRAP_VECTOR;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc_q   <= RESET_VECTOR;
            cnt_q  <= '0;
            top_q  <= '0;
            miss_q <= 1'b0;
            mis_q  <= 1'b0;
        end else begin
            pc_q   <= pc_d;
            cnt_q  <= cnt_d;
            top_q  <= top_d;
            miss_q <= miss_d;
            mis_q  <= mis_d;
        end
    end

    // Stack storage holds no reset value; entries beyond ras_count are never read.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            ras_q[wr_idx] <= seq_pc;
        end
    end

    assign instruction_addr = pc_q;
    assign ras_count        = cnt_q;
    assign ras_miss         = miss_q;
    assign misaligned       = mis_q;

endmodule
